// File: rtl/booth_product_accum.sv
// booth_product_accum: sums N_TERMS signed Booth products into a saturating
// accumulator and emits each finished sum on a valid/ready result stream.
module booth_product_accum #(
  parameter int PROD_W  = 8,
  parameter int ACC_W   = 16,
  parameter int N_TERMS = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clr,
  input  logic                           prod_valid,
  output logic                           prod_ready,
  input  logic [PROD_W-1:0]              prod_data,
  output logic                           res_valid,
  input  logic                           res_ready,
  output logic [ACC_W-1:0]               res_data,
  output logic                           res_sat,
  output logic [$clog2(N_TERMS+1)-1:0]   term_cnt
);

  localparam int CNT_W = $clog2(N_TERMS + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_TERMS - 1);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     sat_q, sat_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [ACC_W-1:0]         res_data_q, res_data_d;
  logic                     res_sat_q, res_sat_d;

  logic [ACC_W:0]           add_res;
  logic                     add_ovf;
  logic [ACC_W-1:0]         add_val;

  // Add one sign-extended product at ACC_W+1 bits; clamp to the ACC_W range.
  // Returns {overflow, clamped_sum}.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                             input logic [PROD_W-1:0] p);
    logic [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {{(ACC_W + 1 - PROD_W){p[PROD_W-1]}}, p};
    if (s[ACC_W] != s[ACC_W-1]) begin
      if (s[ACC_W]) sat_add = {1'b1, 1'b1, {(ACC_W-1){1'b0}}};
      else          sat_add = {1'b1, 1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      sat_add = {1'b0, s[ACC_W-1:0]};
    end
  endfunction

  assign add_res = sat_add(acc_q, prod_data);
  assign add_ovf = add_res[ACC_W];
  assign add_val = add_res[ACC_W-1:0];

  // Next-state, accumulation and handshake logic; clr overrides everything.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    sat_d      = sat_q;
    cnt_d      = cnt_q;
    res_data_d = res_data_q;
    res_sat_d  = res_sat_q;
    prod_ready = 1'b0;
    if (clr) begin
      state_d = ACCUM;
      acc_d   = '0;
      sat_d   = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ACCUM: begin
          prod_ready = 1'b1;
          if (prod_valid) begin
            acc_d = add_val;
            sat_d = sat_q | add_ovf;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_IDX) begin
              res_data_d = add_val;
              res_sat_d  = sat_q | add_ovf;
              state_d    = HOLD;
            end
          end
        end
        HOLD: begin
          if (res_ready) begin
            state_d = ACCUM;
            acc_d   = '0;
            sat_d   = 1'b0;
            cnt_d   = '0;
          end
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ACCUM;
      acc_q      <= '0;
      sat_q      <= 1'b0;
      cnt_q      <= '0;
      res_data_q <= '0;
      res_sat_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      sat_q      <= sat_d;
      cnt_q      <= cnt_d;
      res_data_q <= res_data_d;
      res_sat_q  <= res_sat_d;
    end
  end

  assign res_valid = (state_q == HOLD);
  assign res_data  = res_data_q;
  assign res_sat   = res_sat_q;
  assign term_cnt  = cnt_q;

endmodule

// File: tb/tb_booth_product_accum.sv
// Testbench for booth_product_accum: a default (ACC_W=16) and a narrow
// (ACC_W=9) instance share all inputs and are checked against a reference model.
module tb_booth_product_accum;

  localparam int NT = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       prod_valid = 1'b0;
  logic [7:0] prod_data = '0;
  logic       res_ready = 1'b0;

  logic        a_prod_ready, a_res_valid, a_res_sat;
  logic [15:0] a_res_data;
  logic [2:0]  a_term_cnt;
  logic        b_prod_ready, b_res_valid, b_res_sat;
  logic [8:0]  b_res_data;
  logic [2:0]  b_term_cnt;

  always #5 clk = ~clk;

  booth_product_accum #(.PROD_W(8), .ACC_W(16), .N_TERMS(NT)) dut_a (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .prod_valid(prod_valid), .prod_ready(a_prod_ready), .prod_data(prod_data),
    .res_valid(a_res_valid), .res_ready(res_ready), .res_data(a_res_data),
    .res_sat(a_res_sat), .term_cnt(a_term_cnt)
  );

  booth_product_accum #(.PROD_W(8), .ACC_W(9), .N_TERMS(NT)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .prod_valid(prod_valid), .prod_ready(b_prod_ready), .prod_data(prod_data),
    .res_valid(b_res_valid), .res_ready(res_ready), .res_data(b_res_data),
    .res_sat(b_res_sat), .term_cnt(b_term_cnt)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: products of the current group, hold flag, last results.
  int grp[$];
  bit m_hold = 1'b0;
  int m_res_a = 0, m_res_b = 0;
  bit m_sat_a = 1'b0, m_sat_b = 1'b0;

  typedef struct {
    bit c; bit v; int d; bit r;
    bit e_pr; bit e_rv; int e_cnt; int e_data;
  } vec_t;
  vec_t tbl[14];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void ref_sum(input int accw, output int r, output bit s);
    int hi, lo;
    hi = (1 << (accw - 1)) - 1;
    lo = -(1 << (accw - 1));
    r = 0;
    s = 1'b0;
    foreach (grp[i]) begin
      r = r + grp[i];
      if (r > hi) begin r = hi; s = 1'b1; end
      else if (r < lo) begin r = lo; s = 1'b1; end
    end
  endfunction

  task automatic model_reset();
    grp.delete();
    m_hold = 1'b0;
    m_res_a = 0; m_res_b = 0;
    m_sat_a = 1'b0; m_sat_b = 1'b0;
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, "_res_valid_a"}, a_res_valid, m_hold);
    chk({tag, "_res_valid_b"}, b_res_valid, m_hold);
    chk({tag, "_term_cnt_a"}, a_term_cnt, grp.size());
    chk({tag, "_term_cnt_b"}, b_term_cnt, grp.size());
    chk({tag, "_res_data_a"}, $signed(a_res_data), m_res_a);
    chk({tag, "_res_data_b"}, $signed(b_res_data), m_res_b);
    chk({tag, "_res_sat_a"}, a_res_sat, m_sat_a);
    chk({tag, "_res_sat_b"}, b_res_sat, m_sat_b);
  endtask

  // One clock: drive at posedge+1, check ready before the edge, outputs after it.
  task automatic cyc(input bit c, input bit v, input int d, input bit r,
                     output bit pr_seen);
    bit exp_pr;
    clr = c; prod_valid = v; prod_data = d[7:0]; res_ready = r;
    #1;
    exp_pr = !m_hold && !c;
    pr_seen = a_prod_ready;
    chk("prod_ready_a", a_prod_ready, exp_pr);
    chk("prod_ready_b", b_prod_ready, exp_pr);
    @(posedge clk);
    if (c) begin
      grp.delete(); m_hold = 1'b0;
    end else if (m_hold) begin
      if (r) begin grp.delete(); m_hold = 1'b0; end
    end else if (v) begin
      grp.push_back(d);
      if (grp.size() == NT) begin
        ref_sum(16, m_res_a, m_sat_a);
        ref_sum(9, m_res_b, m_sat_b);
        m_hold = 1'b1;
      end
    end
    #1;
    chk_outputs("cyc");
  endtask

  task automatic put(input int d);
    bit pr;
    cyc(1'b0, 1'b1, d, 1'b0, pr);
  endtask

  initial begin
    bit pr;
    int d;
    logic signed [7:0] t8;

    tbl[0]  = '{0, 1,  10, 1, 1, 0, 1, 0};
    tbl[1]  = '{0, 1,  -3, 1, 1, 0, 2, 0};
    tbl[2]  = '{0, 1,   7, 1, 1, 0, 3, 0};
    tbl[3]  = '{0, 1,  -1, 1, 1, 1, 4, 13};
    tbl[4]  = '{0, 1,  99, 1, 0, 0, 0, 13};
    tbl[5]  = '{0, 0,   0, 1, 1, 0, 0, 13};
    tbl[6]  = '{0, 1,   5, 1, 1, 0, 1, 13};
    tbl[7]  = '{0, 0,   0, 1, 1, 0, 1, 13};
    tbl[8]  = '{0, 0,   0, 1, 1, 0, 1, 13};
    tbl[9]  = '{0, 1,   6, 1, 1, 0, 2, 13};
    tbl[10] = '{0, 0,   0, 1, 1, 0, 2, 13};
    tbl[11] = '{0, 1,  -2, 1, 1, 0, 3, 13};
    tbl[12] = '{0, 1,   9, 1, 1, 1, 4, 18};
    tbl[13] = '{0, 0,   0, 1, 0, 0, 0, 18};

    model_reset();
    #12;
    chk_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_prod_ready", a_prod_ready, 1);

    // Back-to-back group and gapped group from the vector table.
    for (int i = 0; i < 14; i++) begin
      cyc(tbl[i].c, tbl[i].v, tbl[i].d, tbl[i].r, pr);
      chk($sformatf("tbl%0d_prod_ready", i), pr, tbl[i].e_pr);
      chk($sformatf("tbl%0d_res_valid", i), a_res_valid, tbl[i].e_rv);
      chk($sformatf("tbl%0d_term_cnt", i), a_term_cnt, tbl[i].e_cnt);
      chk($sformatf("tbl%0d_res_data", i), $signed(a_res_data), tbl[i].e_data);
    end

    // Saturation in the narrow instance.
    put(127); put(127); put(127); put(-128);
    chk("sat_pos_data_b", $signed(b_res_data), 127);
    chk("sat_pos_flag_b", b_res_sat, 1);
    chk("sat_pos_data_a", $signed(a_res_data), 253);
    chk("sat_pos_flag_a", a_res_sat, 0);
    cyc(1'b0, 1'b0, 0, 1'b1, pr);
    put(-128); put(-128); put(-128); put(-128);
    chk("sat_neg_data_b", $signed(b_res_data), -256);
    chk("sat_neg_flag_b", b_res_sat, 1);
    chk("sat_neg_data_a", $signed(a_res_data), -512);
    cyc(1'b0, 1'b0, 0, 1'b1, pr);
    chk("sat_clean_flag_b", b_res_sat, 1);

    // Backpressure: result held, no product consumed.
    put(1); put(2); put(3); put(4);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b1, 77, 1'b0, pr);
      chk("bp_prod_ready", pr, 0);
      chk("bp_res_data", $signed(a_res_data), 10);
      chk("bp_term_cnt", a_term_cnt, 4);
    end
    cyc(1'b0, 1'b1, 77, 1'b1, pr);
    chk("bp_release_valid", a_res_valid, 0);
    put(2); put(2); put(2); put(2);
    chk("bp_next_group", $signed(a_res_data), 8);
    chk("bp_next_sat", b_res_sat, 0);
    cyc(1'b0, 1'b0, 0, 1'b1, pr);

    // clr mid-group with a same-cycle product, then clr in HOLD.
    put(3); put(4);
    cyc(1'b1, 1'b1, 50, 1'b0, pr);
    chk("clr_prod_ready", pr, 0);
    chk("clr_term_cnt", a_term_cnt, 0);
    put(1); put(1); put(1); put(1);
    chk("clr_group_data", $signed(a_res_data), 4);
    chk("clr_group_valid", a_res_valid, 1);
    cyc(1'b1, 1'b0, 0, 1'b0, pr);
    chk("clr_hold_valid", a_res_valid, 0);
    chk("clr_hold_data_kept", $signed(a_res_data), 4);

    // Asynchronous reset mid-group.
    put(20); put(30); put(40);
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_outputs("async_rst");
    @(posedge clk); #1;
    chk_outputs("async_rst_hold");
    rst_n = 1'b1;
    put(6); put(7); put(8); put(9);
    chk("post_rst_data", $signed(a_res_data), 30);
    cyc(1'b0, 1'b0, 0, 1'b1, pr);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      t8 = 8'($urandom);
      d = t8;
      if ($urandom_range(0, 3) == 0) d = ($urandom_range(0, 1) != 0) ? 127 : -128;
      cyc(($urandom_range(0, 24) == 0), ($urandom_range(0, 3) != 0), d,
          ($urandom_range(0, 2) != 0), pr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
